case2_stream: RTL and testbench

CASE2_STREAM -- requirements
Module: case2_stream

---
 rtl/case2_pkg.sv | 10 +
 rtl/case2_chan_cnt.sv | 27 ++
 rtl/case2_stream.sv | 123 ++++++++++++
 tb/tb_case2_stream.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/case2_pkg.sv
// Shared constants for the case2 stream block: default sizing and beat mode encoding.
package case2_pkg;

    localparam int NCH_DEF   = 4;
    localparam int CNT_W_DEF = 8;

    localparam logic MODE_LEGACY = 1'b0;
    localparam logic MODE_EXT    = 1'b1;

endpackage

// File: rtl/case2_chan_cnt.sv
// Single saturating hit counter. Clear wins over a coincident increment.
module case2_chan_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_reg;

    // Count up on inc, stick at all-ones, clear has priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (inc && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/case2_stream.sv
// Two-stage valid/ready pipeline evaluating three per-channel logic functions
// of five operands, with one saturating hit counter per channel.
module case2_stream
    import case2_pkg::*;
#(
    parameter int NCH   = NCH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NCH-1:0]       a,
    input  logic [NCH-1:0]       b,
    input  logic [NCH-1:0]       c,
    input  logic [NCH-1:0]       d,
    input  logic [NCH-1:0]       e,
    input  logic                 mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NCH-1:0]       x,
    output logic [NCH-1:0]       y,
    output logic [NCH-1:0]       z,
    input  logic                 cnt_clr,
    output logic [NCH*CNT_W-1:0] hit_cnt
);

    // Stage 1: captured operands and mode.
    logic           s1_valid_reg;
    logic [NCH-1:0] s1_a_reg, s1_b_reg, s1_c_reg, s1_d_reg, s1_e_reg;
    logic           s1_mode_reg;

    // Stage 2: registered results.
    logic           s2_valid_reg;
    logic [NCH-1:0] x_reg, y_reg, z_reg;

    // Results computed from stage-1 contents.
    logic [NCH-1:0] x_next, y_next, z_next;

    logic s1_rdy, s2_rdy;
    logic out_fire;

    // Ready ripples backwards combinationally so a full pipe still moves every cycle.
    assign s2_rdy   = ~s2_valid_reg | out_ready;
    assign s1_rdy   = ~s1_valid_reg | s2_rdy;
    assign in_ready = s1_rdy;
    assign out_fire = s2_valid_reg & out_ready;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_logic
            logic [2:0] ones;
            logic       maj;

            assign ones = {2'b00, s1_a_reg[gi]} + {2'b00, s1_b_reg[gi]} + {2'b00, s1_c_reg[gi]}
                        + {2'b00, s1_d_reg[gi]} + {2'b00, s1_e_reg[gi]};
            assign maj  = (ones >= 3'd3);

            assign x_next[gi] = s1_a_reg[gi] & s1_b_reg[gi] & (s1_c_reg[gi] | s1_d_reg[gi]) & ~s1_e_reg[gi];
            assign y_next[gi] = ~(s1_a_reg[gi] & s1_b_reg[gi] & s1_c_reg[gi] & s1_d_reg[gi] & s1_e_reg[gi]);
            assign z_next[gi] = (s1_mode_reg == MODE_EXT) ? maj : y_next[gi];
        end
    endgenerate

    // Stage 1 accepts a new beat whenever it is empty or its occupant moves on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_a_reg     <= '0;
            s1_b_reg     <= '0;
            s1_c_reg     <= '0;
            s1_d_reg     <= '0;
            s1_e_reg     <= '0;
            s1_mode_reg  <= MODE_LEGACY;
        end else if (s1_rdy) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_a_reg    <= a;
                s1_b_reg    <= b;
                s1_c_reg    <= c;
                s1_d_reg    <= d;
                s1_e_reg    <= e;
                s1_mode_reg <= mode;
            end
        end
    end

    // Stage 2 holds its results steady while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_reg <= 1'b0;
            x_reg        <= '0;
            y_reg        <= '0;
            z_reg        <= '0;
        end else if (s2_rdy) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                x_reg <= x_next;
                y_reg <= y_next;
                z_reg <= z_next;
            end
        end
    end

    assign out_valid = s2_valid_reg;
    assign x         = x_reg;
    assign y         = y_reg;
    assign z         = z_reg;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_cnt
            case2_chan_cnt #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk (clk),
                .rst (rst),
                .clr (cnt_clr),
                .inc (out_fire & x_reg[gi]),
                .cnt (hit_cnt[gi*CNT_W +: CNT_W])
            );
        end
    endgenerate

endmodule

// File: tb/tb_case2_stream.sv
// Directed plus random bench for case2_stream against a beat-level reference model.
module tb_case2_stream;

    localparam int NCH   = 4;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [NCH-1:0]       a, b, c, d, e;
    logic                 mode;
    logic                 out_valid;
    logic                 out_ready;
    logic [NCH-1:0]       x, y, z;
    logic                 cnt_clr;
    logic [NCH*CNT_W-1:0] hit_cnt;

    case2_stream #(
        .NCH   (NCH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .e         (e),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x         (x),
        .y         (y),
        .z         (z),
        .cnt_clr   (cnt_clr),
        .hit_cnt   (hit_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NCH-1:0] x;
        logic [NCH-1:0] y;
        logic [NCH-1:0] z;
        int             acc;
    } beat_t;

    beat_t q[$];
    int    cnt_m[NCH];
    int    errors = 0;
    int    checks = 0;
    int    cyc    = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected results of one beat, straight from the boolean definitions.
    function automatic beat_t model(input logic [NCH-1:0] ia, input logic [NCH-1:0] ib,
                                    input logic [NCH-1:0] ic, input logic [NCH-1:0] id,
                                    input logic [NCH-1:0] ie, input logic im, input int acc);
        beat_t r;
        for (int i = 0; i < NCH; i++) begin
            int ones;
            ones = int'(ia[i]) + int'(ib[i]) + int'(ic[i]) + int'(id[i]) + int'(ie[i]);
            r.x[i] = ia[i] && ib[i] && (ic[i] || id[i]) && !ie[i];
            r.y[i] = (ones != 5);
            r.z[i] = im ? (ones >= 3) : r.y[i];
        end
        r.acc = acc;
        return r;
    endfunction

    // One clock: check outputs, advance the model, step to the next falling edge.
    task automatic cycle(output bit in_hs, output bit out_hs);
        bit                   ov_exp;
        bit                   ir_exp;
        logic [NCH*CNT_W-1:0] cexp;
        #1;
        ov_exp = (q.size() > 0) && (cyc - q[0].acc >= 2);
        ir_exp = (q.size() < 2) || out_ready;
        check("out_valid", 64'(out_valid), 64'(ov_exp));
        check("in_ready", 64'(in_ready), 64'(ir_exp));
        if (ov_exp) begin
            check("xyz", 64'({x, y, z}), 64'({q[0].x, q[0].y, q[0].z}));
        end
        for (int i = 0; i < NCH; i++) cexp[i*CNT_W +: CNT_W] = CNT_W'(cnt_m[i]);
        check("hit_cnt", 64'(hit_cnt), 64'(cexp));
        in_hs  = in_valid && ir_exp;
        out_hs = ov_exp && out_ready;
        if (cnt_clr) begin
            for (int i = 0; i < NCH; i++) cnt_m[i] = 0;
        end else if (out_hs) begin
            for (int i = 0; i < NCH; i++)
                if (q[0].x[i] && cnt_m[i] < CMAX) cnt_m[i]++;
        end
        if (out_hs) void'(q.pop_front());
        if (in_hs) q.push_back(model(a, b, c, d, e, mode, cyc));
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic rand_inputs();
        a    = NCH'($urandom);
        b    = NCH'($urandom);
        c    = NCH'($urandom);
        d    = NCH'($urandom);
        e    = NCH'($urandom);
        mode = 1'($urandom);
    endtask

    task automatic set_ops(input logic [NCH-1:0] ia, input logic [NCH-1:0] ib, input logic [NCH-1:0] ic,
                           input logic [NCH-1:0] id, input logic [NCH-1:0] ie, input logic im);
        a = ia; b = ib; c = ic; d = id; e = ie; mode = im;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
        check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
        check({tag, "_xyz"}, 64'({x, y, z}), 64'(0));
        check({tag, "_hit_cnt"}, 64'(hit_cnt), 64'(0));
    endtask

    initial begin
        bit             ih, oh;
        int             k;
        int             outs;
        bit             done;
        logic [NCH-1:0] bp_a[4], bp_b[4], bp_c[4], bp_d[4], bp_e[4];
        logic           bp_m[4];

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
        set_ops('0, '0, '0, '0, '0, 1'b0);
        for (int i = 0; i < NCH; i++) cnt_m[i] = 0;
        #1;
        check_reset_state("reset");
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Truth check: ch0 = 11100, ch1 = 11111, legacy mode.
        out_ready = 1'b1; in_valid = 1'b1;
        set_ops(4'b0011, 4'b0011, 4'b0011, 4'b0010, 4'b0010, 1'b0);
        cycle(ih, oh);
        in_valid = 1'b0;
        cycle(ih, oh);
        check("truth_x", 64'(x[1:0]), 64'(2'b01));
        check("truth_y", 64'(y[1:0]), 64'(2'b01));
        check("truth_z", 64'(z[1:0]), 64'(2'b01));
        cycle(ih, oh);

        // Extended mode: ch0 = 00111 gives majority 1, ch0 = 10001 gives 0.
        in_valid = 1'b1;
        set_ops(4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 1'b1);
        cycle(ih, oh);
        set_ops(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b1);
        cycle(ih, oh);
        in_valid = 1'b0;
        check("ext_x0", 64'(x[0]), 64'(0));
        check("ext_y0", 64'(y[0]), 64'(1));
        check("ext_z0_maj", 64'(z[0]), 64'(1));
        cycle(ih, oh);
        check("ext_z0_min", 64'(z[0]), 64'(0));
        cycle(ih, oh);

        // Backpressure: four queued beats against a 5-cycle stall.
        for (int i = 0; i < 4; i++) begin
            bp_a[i] = NCH'($urandom); bp_b[i] = NCH'($urandom); bp_c[i] = NCH'($urandom);
            bp_d[i] = NCH'($urandom); bp_e[i] = NCH'($urandom); bp_m[i] = 1'($urandom);
        end
        out_ready = 1'b0;
        k = 0;
        for (int t = 0; t < 5; t++) begin
            in_valid = (k < 4);
            if (k < 4) set_ops(bp_a[k], bp_b[k], bp_c[k], bp_d[k], bp_e[k], bp_m[k]);
            cycle(ih, oh);
            if (ih) k++;
        end
        check("bp_accepted_while_stalled", 64'(k), 64'(2));
        out_ready = 1'b1;
        done = 1'b0;
        for (int t = 0; t < 20 && !done; t++) begin
            in_valid = (k < 4);
            if (k < 4) set_ops(bp_a[k], bp_b[k], bp_c[k], bp_d[k], bp_e[k], bp_m[k]);
            cycle(ih, oh);
            if (ih) k++;
            done = (k == 4) && (q.size() == 0);
        end
        in_valid = 1'b0;
        check("bp_drained", 64'(done), 64'(1));

        // Saturation: 260 handshakes with every channel hitting.
        in_valid = 1'b1; out_ready = 1'b1;
        set_ops(4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 1'b0);
        outs = 0;
        for (int t = 0; t < 300 && outs < 260; t++) begin
            cycle(ih, oh);
            if (oh) outs++;
        end
        check("sat_handshakes", 64'(outs), 64'(260));
        check("sat_ch2", 64'(hit_cnt[2*CNT_W +: CNT_W]), 64'(255));
        cnt_clr = 1'b1;
        cycle(ih, oh);
        cnt_clr = 1'b0;
        check("clr_with_hit", 64'(hit_cnt[2*CNT_W +: CNT_W]), 64'(0));
        check("clr_handshake", 64'(oh), 64'(1));

        // Random traffic.
        for (int t = 0; t < 400; t++) begin
            rand_inputs();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            cnt_clr   = ($urandom_range(0, 19) == 0);
            cycle(ih, oh);
        end
        cnt_clr = 1'b0;

        // Reset mid-stream with two beats in flight.
        out_ready = 1'b1; in_valid = 1'b1;
        rand_inputs();
        cycle(ih, oh);
        rand_inputs();
        cycle(ih, oh);
        in_valid = 1'b0;
        while (q.size() < 2 && cyc < 90000) begin
            in_valid = 1'b1;
            cycle(ih, oh);
            in_valid = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        check_reset_state("midrst");
        q.delete();
        for (int i = 0; i < NCH; i++) cnt_m[i] = 0;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_reset_state("midrst_hold");
        rst = 1'b0;
        in_valid = 1'b1;
        rand_inputs();
        cycle(ih, oh);
        check("post_rst_accept", 64'(ih), 64'(1));
        in_valid = 1'b0;
        cycle(ih, oh);
        check("post_rst_latency", 64'(out_valid), 64'(1));

        // More random traffic, then drain.
        for (int t = 0; t < 200; t++) begin
            rand_inputs();
            in_valid  = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            cnt_clr   = ($urandom_range(0, 29) == 0);
            cycle(ih, oh);
        end
        in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
        for (int t = 0; t < 5; t++) cycle(ih, oh);
        check("final_empty", 64'(out_valid), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
